airi5c_spi_ahb: RTL and testbench

//  AHB-lite (HASTI) slave SPI peripheral: 8-bit frames, SPI mode 0, 4-entry TX/RX FIFOs.

---
 rtl/airi5c_spi_ahb.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_airi5c_spi_ahb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/airi5c_spi_ahb.sv
`default_nettype none
// ============================================================================
// Module      : airi5c_spi_ahb (plus helper airi5c_spi_fifo)
// Description : AHB-lite SPI peripheral, 8-bit mode-0 frames, master or
//               slave operation, 4-entry TX and RX FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================

module airi5c_spi_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    logic [7:0] r_mem [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_cnt;
    logic       w_pop;
    logic       w_push;

    // A push into a full FIFO is still accepted when a pop frees the slot
    assign w_pop  = pop & (r_cnt != 3'd0);
    assign w_push = push & ((r_cnt != 3'd4) | w_pop);
    assign rdata  = r_mem[r_rp];
    assign empty  = (r_cnt == 3'd0);
    assign full   = (r_cnt == 3'd4);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (w_push) r_wp <= r_wp + 2'd1;
            if (w_pop)  r_rp <= r_rp + 2'd1;
            r_cnt <= r_cnt + {2'b0, w_push} - {2'b0, w_pop};
        end
    end

    // Storage array, contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= wdata;
    end
endmodule

module airi5c_spi_ahb #(
    parameter logic [31:0] BASE_ADDR      = 32'hC0000020,
    parameter int          CLK_FREQ_KHZ   = 32000,
    parameter bit          DEFAULT_MASTER = 1'b1,
    parameter bit          DEFAULT_SD     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        master_mosi,
    input  logic        master_miso,
    output logic        master_sclk,
    output logic        master_nss,
    input  logic        slave_mosi,
    output logic        slave_miso,
    input  logic        slave_sclk,
    input  logic        slave_nss,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);
    localparam int         c_div_calc = CLK_FREQ_KHZ / 2000;
    localparam logic [7:0] c_div_rst  = (c_div_calc > 255) ? 8'd255 : 8'(c_div_calc);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_lead  = 3'd1;
    localparam logic [2:0] c_st_high  = 3'd2;
    localparam logic [2:0] c_st_low   = 3'd3;
    localparam logic [2:0] c_st_trail = 3'd4;
    localparam logic [2:0] c_st_gap   = 3'd5;

    // Bus pipeline and control registers
    logic       r_dph, r_wr;
    logic [1:0] r_off;
    logic [7:0] r_div;
    logic       r_sd, r_master, r_ovf;
    logic       w_hit, w_rd, w_data_wr, w_ctrl_wr, w_data_rd, w_stat_rd;
    logic       w_unused_bus;

    // FIFO hookups
    logic [7:0] tx_rdata, rx_rdata, rx_wdata;
    logic       tx_empty, tx_full, rx_empty, rx_full, tx_pop, rx_push;

    // Master engine
    logic [2:0] r_m_state, r_m_bit;
    logic [7:0] r_m_cnt, r_m_h, r_m_tx, r_m_rx;
    logic       r_m_sd, r_m_sclk, r_m_nss, r_m_mosi;
    logic [7:0] w_m_tx_next, w_m_rx_next;
    logic       w_m_pop, w_m_push;

    // Slave engine
    logic [2:0] r_s_nss, r_s_sclk, r_s_bit;
    logic [1:0] r_s_mosi;
    logic [7:0] r_s_tx, r_s_rx, w_s_rx_next;
    logic       r_s_act, r_s_sd;
    logic       w_nss_fall, w_nss_rise, w_sclk_rise, w_sclk_fall, w_s_run, w_s_pop, w_s_push;

    assign w_unused_bus = ^{haddr[1:0], hwdata[31:8], hsize, hburst, hmastlock, hprot, htrans};
    assign hready = 1'b1;
    assign hresp  = 1'b0;

    assign w_hit     = (haddr[31:4] == BASE_ADDR[31:4]);
    assign w_rd      = r_dph & ~r_wr;
    assign w_data_wr = r_dph & r_wr & (r_off == 2'd1);
    assign w_ctrl_wr = r_dph & r_wr & (r_off == 2'd2);
    assign w_data_rd = w_rd & (r_off == 2'd1);
    assign w_stat_rd = w_rd & (r_off == 2'd0);

    // Address phase capture; write data arrives in the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dph <= 1'b0;
            r_wr  <= 1'b0;
            r_off <= 2'd0;
        end else begin
            r_dph <= w_hit;
            r_wr  <= hwrite;
            r_off <= haddr[3:2];
        end
    end

    // Control register and sticky overflow flag (a new overflow beats the clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= c_div_rst;
            r_sd     <= DEFAULT_SD;
            r_master <= DEFAULT_MASTER;
            r_ovf    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_div    <= hwdata[7:0];
                r_sd     <= hwdata[12];
                r_master <= hwdata[14];
            end
            if (rx_push & rx_full & ~w_data_rd) r_ovf <= 1'b1;
            else if (w_stat_rd)                 r_ovf <= 1'b0;
        end
    end

    // Data-phase read mux
    always_comb begin
        hrdata = 32'd0;
        if (w_rd) begin
            case (r_off)
                2'd0:    hrdata = {26'd0, r_ovf, (r_m_state != c_st_idle), rx_full, rx_empty, tx_full, tx_empty};
                2'd1:    hrdata = {24'd0, (rx_empty ? 8'h00 : rx_rdata)};
                2'd2:    hrdata = {17'd0, r_master, 1'b0, r_sd, 4'd0, r_div};
                default: hrdata = 32'd0;
            endcase
        end
    end

    assign tx_pop   = w_m_pop | w_s_pop;
    assign rx_push  = w_m_push | w_s_push;
    assign rx_wdata = w_m_push ? r_m_rx : w_s_rx_next;

    airi5c_spi_fifo u_tx (.clk(clk), .reset(reset), .push(w_data_wr), .wdata(hwdata[7:0]),
                          .pop(tx_pop), .rdata(tx_rdata), .empty(tx_empty), .full(tx_full));
    airi5c_spi_fifo u_rx (.clk(clk), .reset(reset), .push(rx_push), .wdata(rx_wdata),
                          .pop(w_data_rd), .rdata(rx_rdata), .empty(rx_empty), .full(rx_full));

    assign master_sclk = r_m_sclk;
    assign master_nss  = r_m_nss;
    assign master_mosi = r_m_mosi;
    assign w_m_pop     = (r_m_state == c_st_idle) & r_master & ~tx_empty;
    assign w_m_push    = (r_m_state == c_st_trail) & (r_m_cnt == 8'd0);
    assign w_m_tx_next = r_m_sd ? {r_m_tx[6:0], 1'b0} : {1'b0, r_m_tx[7:1]};
    assign w_m_rx_next = r_m_sd ? {r_m_rx[6:0], master_miso} : {master_miso, r_m_rx[7:1]};

    // Master frame sequencer; every phase lasts DIV+1 clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_state <= c_st_idle;
            r_m_cnt   <= 8'd0;
            r_m_h     <= 8'd0;
            r_m_bit   <= 3'd0;
            r_m_tx    <= 8'd0;
            r_m_rx    <= 8'd0;
            r_m_sd    <= 1'b0;
            r_m_sclk  <= 1'b0;
            r_m_nss   <= 1'b1;
            r_m_mosi  <= 1'b0;
        end else begin
            if (r_m_state != c_st_idle && r_m_cnt != 8'd0) begin
                r_m_cnt <= r_m_cnt - 8'd1;
            end else begin
                case (r_m_state)
                    c_st_idle: if (w_m_pop) begin
                        r_m_state <= c_st_lead;
                        r_m_nss   <= 1'b0;
                        r_m_h     <= r_div;
                        r_m_cnt   <= r_div;
                        r_m_sd    <= r_sd;
                        r_m_tx    <= tx_rdata;
                        r_m_mosi  <= r_sd ? tx_rdata[7] : tx_rdata[0];
                        r_m_bit   <= 3'd0;
                    end
                    c_st_lead: begin
                        r_m_state <= c_st_high;
                        r_m_sclk  <= 1'b1;
                        r_m_rx    <= w_m_rx_next;
                        r_m_cnt   <= r_m_h;
                    end
                    c_st_high: begin
                        r_m_state <= c_st_low;
                        r_m_sclk  <= 1'b0;
                        r_m_tx    <= w_m_tx_next;
                        r_m_mosi  <= r_m_sd ? w_m_tx_next[7] : w_m_tx_next[0];
                        r_m_cnt   <= r_m_h;
                    end
                    c_st_low: begin
                        r_m_cnt <= r_m_h;
                        if (r_m_bit == 3'd7) begin
                            r_m_state <= c_st_trail;
                        end else begin
                            r_m_state <= c_st_high;
                            r_m_sclk  <= 1'b1;
                            r_m_rx    <= w_m_rx_next;
                            r_m_bit   <= r_m_bit + 3'd1;
                        end
                    end
                    c_st_trail: begin
                        r_m_state <= c_st_gap;
                        r_m_nss   <= 1'b1;
                        r_m_mosi  <= 1'b0;
                        r_m_cnt   <= r_m_h;
                    end
                    default: r_m_state <= c_st_idle;
                endcase
            end
        end
    end

    // Two-flop synchronisers, third stage kept for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_nss  <= 3'b111;
            r_s_sclk <= 3'b000;
            r_s_mosi <= 2'b00;
        end else begin
            r_s_nss  <= {r_s_nss[1:0], slave_nss};
            r_s_sclk <= {r_s_sclk[1:0], slave_sclk};
            r_s_mosi <= {r_s_mosi[0], slave_mosi};
        end
    end

    assign w_nss_fall  = r_s_nss[2] & ~r_s_nss[1];
    assign w_nss_rise  = ~r_s_nss[2] & r_s_nss[1];
    assign w_sclk_rise = ~r_s_sclk[2] & r_s_sclk[1];
    assign w_sclk_fall = r_s_sclk[2] & ~r_s_sclk[1];
    assign w_s_pop     = w_nss_fall & ~r_master;
    assign w_s_run     = r_s_act & ~w_nss_rise & ~w_s_pop;
    assign w_s_push    = w_s_run & w_sclk_rise & (r_s_bit == 3'd7);
    assign w_s_rx_next = r_s_sd ? {r_s_rx[6:0], r_s_mosi[1]} : {r_s_mosi[1], r_s_rx[7:1]};
    assign slave_miso  = r_s_act & (r_s_sd ? r_s_tx[7] : r_s_tx[0]);

    // Slave shifter; deselect mid-byte throws the partial byte away
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_act <= 1'b0;
            r_s_sd  <= 1'b0;
            r_s_bit <= 3'd0;
            r_s_tx  <= 8'd0;
            r_s_rx  <= 8'd0;
        end else if (w_nss_rise) begin
            r_s_act <= 1'b0;
            r_s_bit <= 3'd0;
        end else if (w_s_pop) begin
            r_s_act <= 1'b1;
            r_s_bit <= 3'd0;
            r_s_sd  <= r_sd;
            r_s_tx  <= tx_empty ? 8'h00 : tx_rdata;
        end else if (r_s_act) begin
            if (w_sclk_rise) begin
                r_s_rx  <= w_s_rx_next;
                r_s_bit <= r_s_bit + 3'd1;
            end
            if (w_sclk_fall) begin
                r_s_tx <= r_s_sd ? {r_s_tx[6:0], 1'b0} : {1'b0, r_s_tx[7:1]};
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_airi5c_spi_ahb.sv
`default_nettype none
// ============================================================================
// Module      : tb_airi5c_spi_ahb
// Description : Directed bench: a master instance and a slave instance share
//               one AHB bus and are wired back to back over SPI.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_airi5c_spi_ahb;
    localparam logic [31:0] c_mbase = 32'hC0000020;
    localparam logic [31:0] c_sbase = 32'hC0000030;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] haddr = 32'd0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'd0;
    logic [31:0] hwdata = 32'd0;
    logic [31:0] hrdata_m, hrdata_s, hrdata;
    logic        hready_m, hready_s, hresp_m, hresp_s;

    logic m_mosi, m_sclk, m_nss, m_slave_miso;
    logic s_master_mosi, s_master_sclk, s_master_nss, s_miso;

    int checks = 0;
    int errors = 0;

    // Bus-side monitor state
    int cyc = 0, pulses = 0, frames = 0, period = 0, last_rise = 0;
    logic prev_sclk = 1'b0, prev_nss = 1'b1;

    always #5 clk = ~clk;
    assign hrdata = hrdata_m | hrdata_s;

    airi5c_spi_ahb #(.BASE_ADDR(c_mbase)) u_m (
        .clk(clk), .reset(reset),
        .master_mosi(m_mosi), .master_miso(s_miso), .master_sclk(m_sclk), .master_nss(m_nss),
        .slave_mosi(1'b0), .slave_miso(m_slave_miso), .slave_sclk(1'b0), .slave_nss(1'b1),
        .haddr(haddr), .hwrite(hwrite), .hsize(3'd2), .hburst(3'd0), .hmastlock(1'b0),
        .hprot(4'd0), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata_m), .hready(hready_m), .hresp(hresp_m));

    airi5c_spi_ahb #(.BASE_ADDR(c_sbase)) u_s (
        .clk(clk), .reset(reset),
        .master_mosi(s_master_mosi), .master_miso(1'b0), .master_sclk(s_master_sclk),
        .master_nss(s_master_nss),
        .slave_mosi(m_mosi), .slave_miso(s_miso), .slave_sclk(m_sclk), .slave_nss(m_nss),
        .haddr(haddr), .hwrite(hwrite), .hsize(3'd2), .hburst(3'd0), .hmastlock(1'b0),
        .hprot(4'd0), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata_s), .hready(hready_s), .hresp(hresp_s));

    // Count master sclk pulses inside nss-low, frames, and the last sclk period
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_sclk && !prev_sclk) begin
            if (!m_nss) pulses = pulses + 1;
            period = cyc - last_rise;
            last_rise = cyc;
        end
        if (!m_nss && prev_nss) frames = frames + 1;
        prev_sclk = m_sclk;
        prev_nss  = m_nss;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        haddr = addr; hwrite = 1'b1; htrans = 2'd2;
        @(posedge clk); #1;
        haddr = 32'd0; hwrite = 1'b0; htrans = 2'd0; hwdata = data;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        haddr = addr; hwrite = 1'b0; htrans = 2'd2;
        @(posedge clk); #1;
        haddr = 32'd0; htrans = 2'd0;
        data = hrdata;
        @(posedge clk); #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    // Wait until the frame counter reaches target and nss is back high
    task automatic wait_frames(input string tag, input int target, input int budget);
        int n = 0;
        while (!(frames >= target && m_nss === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int base_p, base_f, n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        #4 check("rst_nss", {31'd0, m_nss}, 32'd1);
        check("rst_sclk", {31'd0, m_sclk}, 32'd0);
        read_check("rst_status", c_mbase + 0, 32'h05);
        read_check("rst_ctrl", c_mbase + 8, 32'h5010);

        // Master DIV=0 sends 0x01 to an empty-TX slave
        bus_write(c_sbase + 8, 32'h1000);
        bus_write(c_mbase + 8, 32'h5000);
        base_p = pulses; base_f = frames;
        bus_write(c_mbase + 4, 32'h01);
        wait_frames("t1_wait", base_f + 1, 300);
        check("t1_pulses", pulses - base_p, 32'd8);
        read_check("t1_slave_rx", c_sbase + 4, 32'h01);
        read_check("t1_master_rx", c_mbase + 4, 32'h00);

        // Full duplex at DIV=3: slave preloaded with 0xA5, master sends 0x3C
        bus_write(c_mbase + 8, 32'h5003);
        bus_write(c_sbase + 4, 32'hA5);
        base_f = frames;
        bus_write(c_mbase + 4, 32'h3C);
        wait_frames("t2_wait", base_f + 1, 400);
        check("t2_period", period, 32'd8);
        read_check("t2_master_rx", c_mbase + 4, 32'hA5);
        read_check("t2_slave_rx", c_sbase + 4, 32'h3C);

        // Five writes while not mastering: TX fills at four, fifth dropped
        bus_write(c_mbase + 8, 32'h1003);
        bus_write(c_mbase + 4, 32'h11);
        bus_write(c_mbase + 4, 32'h22);
        bus_write(c_mbase + 4, 32'h33);
        bus_write(c_mbase + 4, 32'h44);
        bus_write(c_mbase + 4, 32'h55);
        read_check("t3_tx_full", c_mbase + 0, 32'h06);
        base_f = frames;
        bus_write(c_mbase + 8, 32'h5003);
        wait_frames("t3_wait", base_f + 4, 1500);
        repeat (200) @(negedge clk);
        check("t3_frames", frames - base_f, 32'd4);
        read_check("t3_slave_status", c_sbase + 0, 32'h09);

        // Fifth frame into full RX FIFOs sets the sticky overflow
        base_f = frames;
        bus_write(c_mbase + 4, 32'h66);
        wait_frames("t4_wait", base_f + 1, 400);
        read_check("t4_ovf", c_sbase + 0, 32'h29);
        read_check("t4_ovf_clr", c_sbase + 0, 32'h09);
        read_check("t4_rx0", c_sbase + 4, 32'h11);
        read_check("t4_rx1", c_sbase + 4, 32'h22);
        read_check("t4_rx2", c_sbase + 4, 32'h33);
        read_check("t4_rx3", c_sbase + 4, 32'h44);
        read_check("t4_drained", c_sbase + 0, 32'h05);
        read_check("t4_master_ovf", c_mbase + 0, 32'h29);

        // LSB-first frame, then reset in the middle of it
        bus_write(c_mbase + 8, 32'h4003);
        bus_write(c_mbase + 4, 32'h01);
        n = 0;
        while (m_nss !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_nss_low", {31'd0, m_nss}, 32'd0);
        check("t5_first_bit", {31'd0, m_mosi}, 32'd1);
        bus_write(c_mbase + 4, 32'h02);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_nss", {31'd0, m_nss}, 32'd1);
        check("t5_rst_sclk", {31'd0, m_sclk}, 32'd0);
        reset = 1'b0;
        read_check("t5_status", c_mbase + 0, 32'h05);
        read_check("t5_ctrl", c_mbase + 8, 32'h5010);
        read_check("t5_slave_status", c_sbase + 0, 32'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
